// File: rtl/rat_pkg.sv
// Shared types and constants for the RAT CPU flag datapath.
package rat_pkg;

    typedef struct packed {
        logic c;
        logic z;
    } flag_t;

    localparam flag_t FLAG_RST     = '{c: 1'b0, z: 1'b0};
    localparam int    MAX_PEND_DEF = 3;
    localparam int    PEND_W       = $clog2(MAX_PEND_DEF + 1);

endpackage

// File: rtl/rat_pend_counter.sv
// Saturating up/down in-flight counter with flush and a registered busy flag.
module rat_pend_counter #(
    parameter int MAX = 3,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         dec,
    input  logic         flush,
    output logic [W-1:0] count,
    output logic         busy
);

    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    logic [W-1:0] cnt_nxt;

    // Flush wins; inc and dec together cancel; saturate at both ends.
    always_comb begin
        cnt_nxt = count;
        if (flush)
            cnt_nxt = '0;
        else if (inc && !dec && count != MAX_CNT)
            cnt_nxt = count + 1'b1;
        else if (dec && !inc && count != '0)
            cnt_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            busy  <= 1'b0;
        end else begin
            count <= cnt_nxt;
            busy  <= (cnt_nxt != '0);
        end
    end

endmodule

// File: rtl/rat_flag_unit.sv
// C/Z/I flag owner: ALU updates, set/clear ops, interrupt shadow save/restore
// and in-flight flag-writer tracking for branch hold in decode.
module rat_flag_unit
    import rat_pkg::*;
#(
    parameter int MAX_PEND = MAX_PEND_DEF,
    parameter int PW       = $clog2(MAX_PEND + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ALU_C,
    input  logic          ALU_Z,
    input  logic          FLG_C_LD,
    input  logic          FLG_Z_LD,
    input  logic          FLG_C_SET,
    input  logic          FLG_C_CLR,
    input  logic          I_SET,
    input  logic          I_CLR,
    input  logic          INTR_ACK,
    input  logic          RETIE,
    input  logic          FLG_ISSUE,
    input  logic          FLG_RETIRE,
    input  logic          FLUSH,
    output logic          C_FLAG,
    output logic          Z_FLAG,
    output logic          I_FLAG,
    output logic          C_FWD,
    output logic          Z_FWD,
    output logic          FLG_BUSY,
    output logic          SHAD_ERR,
    output logic          SHAD_VALID,
    output logic [PW-1:0] PEND_CNT
);

    flag_t flg;
    flag_t shad;
    flag_t flg_nxt;
    logic  i_reg;
    logic  shad_valid;
    logic  shad_err;

    always_comb begin
        flg_nxt = flg;
        if (RETIE)
            flg_nxt.c = shad.c;
        else if (FLG_C_SET)
            flg_nxt.c = 1'b1;
        else if (FLG_C_CLR)
            flg_nxt.c = 1'b0;
        else if (FLG_C_LD)
            flg_nxt.c = ALU_C;

        if (RETIE)
            flg_nxt.z = shad.z;
        else if (FLG_Z_LD)
            flg_nxt.z = ALU_Z;
    end

    // The shadow captures the next-state flags so a same-cycle ALU write is kept.
    // INTR_ACK owns I and the shadow when it coincides with RETIE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            flg        <= FLAG_RST;
            shad       <= FLAG_RST;
            i_reg      <= 1'b0;
            shad_valid <= 1'b0;
            shad_err   <= 1'b0;
        end else begin
            flg <= flg_nxt;
            if (INTR_ACK) begin
                shad       <= flg_nxt;
                shad_valid <= 1'b1;
                i_reg      <= 1'b0;
                if (shad_valid)
                    shad_err <= 1'b1;
            end else if (RETIE) begin
                shad_valid <= 1'b0;
                i_reg      <= 1'b1;
            end else if (I_CLR) begin
                i_reg <= 1'b0;
            end else if (I_SET) begin
                i_reg <= 1'b1;
            end
        end
    end

    rat_pend_counter #(
        .MAX (MAX_PEND),
        .W   (PW)
    ) u_pend (
        .clk   (CLK),
        .rst   (RST),
        .inc   (FLG_ISSUE),
        .dec   (FLG_RETIRE),
        .flush (FLUSH),
        .count (PEND_CNT),
        .busy  (FLG_BUSY)
    );

    assign C_FLAG     = flg.c;
    assign Z_FLAG     = flg.z;
    assign I_FLAG     = i_reg;
    assign C_FWD      = flg_nxt.c;
    assign Z_FWD      = flg_nxt.z;
    assign SHAD_ERR   = shad_err;
    assign SHAD_VALID = shad_valid;

endmodule

// File: tb/tb_rat_flag_unit.sv
// Directed bench for rat_flag_unit with hand-computed expectations.
module tb_rat_flag_unit;
    import rat_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic alu_c, alu_z, c_ld, z_ld, c_set, c_clr, i_set, i_clr;
    logic intr_ack, retie, issue, retire, flush;
    logic c_flag, z_flag, i_flag, c_fwd, z_fwd, busy, shad_err, shad_valid;
    logic [PEND_W-1:0] pend_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rat_flag_unit dut (
        .CLK(clk), .RST(rst), .ALU_C(alu_c), .ALU_Z(alu_z),
        .FLG_C_LD(c_ld), .FLG_Z_LD(z_ld), .FLG_C_SET(c_set), .FLG_C_CLR(c_clr),
        .I_SET(i_set), .I_CLR(i_clr), .INTR_ACK(intr_ack), .RETIE(retie),
        .FLG_ISSUE(issue), .FLG_RETIRE(retire), .FLUSH(flush),
        .C_FLAG(c_flag), .Z_FLAG(z_flag), .I_FLAG(i_flag),
        .C_FWD(c_fwd), .Z_FWD(z_fwd), .FLG_BUSY(busy), .SHAD_ERR(shad_err),
        .SHAD_VALID(shad_valid), .PEND_CNT(pend_cnt)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        alu_c = 0; alu_z = 0; c_ld = 0; z_ld = 0; c_set = 0; c_clr = 0;
        i_set = 0; i_clr = 0; intr_ack = 0; retie = 0;
        issue = 0; retire = 0; flush = 0;
    endtask

    // Inputs already driven: let the edge happen, drop inputs, settle.
    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic check_all(input string tag, input logic c, input logic z, input logic i,
                             input logic b, input logic e, input logic v,
                             input logic [PEND_W-1:0] p);
        check({tag, ".c"}, 8'(c_flag), 8'(c));
        check({tag, ".z"}, 8'(z_flag), 8'(z));
        check({tag, ".i"}, 8'(i_flag), 8'(i));
        check({tag, ".busy"}, 8'(busy), 8'(b));
        check({tag, ".err"}, 8'(shad_err), 8'(e));
        check({tag, ".sv"}, 8'(shad_valid), 8'(v));
        check({tag, ".cnt"}, 8'(pend_cnt), 8'(p));
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("rst", 0, 0, 0, 0, 0, 0, 0);
        check("rst.cfwd", 8'(c_fwd), 8'd0);
        check("rst.zfwd", 8'(z_fwd), 8'd0);
        rst = 1'b0;

        // ALU load: forward same cycle, registered next edge
        @(posedge clk); #1;
        c_ld = 1; alu_c = 1; z_ld = 1; alu_z = 0;
        #1;
        check("ld.cfwd", 8'(c_fwd), 8'd1);
        check("ld.zfwd", 8'(z_fwd), 8'd0);
        check("ld.c_pre", 8'(c_flag), 8'd0);
        tick();
        check("ld.c", 8'(c_flag), 8'd1);
        check("ld.z", 8'(z_flag), 8'd0);

        z_ld = 1; alu_z = 1; tick();
        check("zld.z", 8'(z_flag), 8'd1);
        c_clr = 1; tick();
        check("clc.c", 8'(c_flag), 8'd0);
        c_set = 1; c_clr = 1; #1;
        check("setclr.cfwd", 8'(c_fwd), 8'd1);
        tick();
        check("setclr.c", 8'(c_flag), 8'd1);
        c_clr = 1; c_ld = 1; alu_c = 1; tick();
        check("clr_over_ld.c", 8'(c_flag), 8'd0);
        i_set = 1; tick();
        check("sei.i", 8'(i_flag), 8'd1);
        i_set = 1; i_clr = 1; tick();
        check("cli_over_sei.i", 8'(i_flag), 8'd0);
        i_set = 1; tick();

        // C=0 Z=1 I=1: interrupt entry captures same-cycle ALU carry
        check_all("pre_int", 0, 1, 1, 0, 0, 0, 0);
        intr_ack = 1; c_ld = 1; alu_c = 1; tick();
        check_all("int", 1, 1, 0, 0, 0, 1, 0);
        c_ld = 1; alu_c = 0; z_ld = 1; alu_z = 0; tick();
        check("isr_alu.c", 8'(c_flag), 8'd0);
        check("isr_alu.z", 8'(z_flag), 8'd0);
        retie = 1; #1;
        check("retie.cfwd", 8'(c_fwd), 8'd1);
        check("retie.zfwd", 8'(z_fwd), 8'd1);
        tick();
        check_all("retie", 1, 1, 1, 0, 0, 0, 0);

        // Nested interrupt entry without return
        intr_ack = 1; tick();
        check("ack1.err", 8'(shad_err), 8'd0);
        intr_ack = 1; tick();
        check("ack2.err", 8'(shad_err), 8'd1);
        retie = 1; tick();
        check("err_sticky", 8'(shad_err), 8'd1);
        check("retie2.i", 8'(i_flag), 8'd1);

        // Pending counter
        for (int k = 1; k <= 3; k++) begin
            issue = 1; tick();
            check($sformatf("issue%0d.cnt", k), 8'(pend_cnt), 8'(k));
            check($sformatf("issue%0d.busy", k), 8'(busy), 8'd1);
        end
        issue = 1; tick();
        check("sat.cnt", 8'(pend_cnt), 8'd3);
        issue = 1; retire = 1; tick();
        check("both.cnt", 8'(pend_cnt), 8'd3);
        for (int k = 2; k >= 0; k--) begin
            retire = 1; tick();
            check($sformatf("retire%0d.cnt", k), 8'(pend_cnt), 8'(k));
        end
        check("drain.busy", 8'(busy), 8'd0);
        retire = 1; tick();
        check("floor.cnt", 8'(pend_cnt), 8'd0);
        check("floor.busy", 8'(busy), 8'd0);

        issue = 1; tick();
        issue = 1; tick();
        check("pre_flush.cnt", 8'(pend_cnt), 8'd2);
        flush = 1; issue = 1; tick();
        check("flush.cnt", 8'(pend_cnt), 8'd0);
        check("flush.busy", 8'(busy), 8'd0);

        // Async reset mid-operation, asserted between edges
        issue = 1; tick();
        issue = 1; tick();
        check_all("pre_rst", 1, 1, 1, 1, 1, 0, 2);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset inside an ISR drops the shadow
        c_set = 1; tick();
        intr_ack = 1; tick();
        check("isr2.sv", 8'(shad_valid), 8'd1);
        #2; rst = 1'b1; #1;
        check("isr2_rst.sv", 8'(shad_valid), 8'd0);
        @(negedge clk);
        rst = 1'b0;
        retie = 1; #1;
        check("no_restore.cfwd", 8'(c_fwd), 8'd0);
        tick();
        check("no_restore.c", 8'(c_flag), 8'd0);
        check("no_restore.err", 8'(shad_err), 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
